// File: rtl/fixed_sat_mult_pipe_if.sv
// Operand/result handshake bundle for the saturating fixed-point multiplier.
// master drives operands and out_ready; slave is the multiplier itself.
interface fixed_sat_mult_pipe_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  a_in;
    logic [IN_W-1:0]  b_in;
    logic             round_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] p_out;
    logic             overflow;
    logic             underflow;

    modport master (
        output in_valid, a_in, b_in, round_mode, out_ready,
        input  in_ready, out_valid, p_out, overflow, underflow
    );

    modport slave (
        input  in_valid, a_in, b_in, round_mode, out_ready,
        output in_ready, out_valid, p_out, overflow, underflow
    );
endinterface

// File: rtl/fixed_sat_mult_pipe.sv
// Three-stage saturating signed Qm.n multiplier with truncate/round-half-up,
// global-stall backpressure and saturating clip-event counters.
module fixed_sat_mult_pipe #(
    parameter int IN_W     = 32,
    parameter int IN_FRAC  = 8,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 8,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fixed_sat_mult_pipe_if.slave bus,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     sat_pos_cnt,
    output logic [CNT_W-1:0]     sat_neg_cnt
);
    localparam int PW    = 2 * IN_W;
    localparam int RW    = PW + 1;
    localparam int SHIFT = 2 * IN_FRAC - OUT_FRAC;

    // Half an output LSB in product units; zero when no bits are dropped.
    localparam logic [RW-1:0] HALF  = (RW'(1) << SHIFT) >> 1;
    localparam logic [RW-1:0] MAX_U = (RW'(1) << (OUT_W - 1)) - RW'(1);
    localparam logic [RW-1:0] MIN_U = RW'(0) - (RW'(1) << (OUT_W - 1));
    localparam logic signed [RW-1:0] MAX_R = $signed(MAX_U);
    localparam logic signed [RW-1:0] MIN_R = $signed(MIN_U);

    logic                    en;
    logic                    acc;

    logic                    v1_q, v1_d;
    logic signed [IN_W-1:0]  a1_q, a1_d;
    logic signed [IN_W-1:0]  b1_q, b1_d;
    logic                    rm1_q, rm1_d;

    logic                    v2_q, v2_d;
    logic signed [PW-1:0]    prod_q, prod_d;
    logic                    rm2_q, rm2_d;

    logic                    v3_q, v3_d;
    logic [OUT_W-1:0]        p_q, p_d;
    logic                    ov_q, ov_d;
    logic                    un_q, un_d;

    logic [CNT_W-1:0]        pos_q, pos_d;
    logic [CNT_W-1:0]        neg_q, neg_d;

    logic signed [RW-1:0]    r;
    logic signed [RW-1:0]    s;
    logic                    s_ov;
    logic                    s_un;

    // Whole pipe advances together; it stalls only on a held result.
    assign en  = bus.out_ready | ~v3_q;
    assign acc = v3_q & bus.out_ready;

    // Round, rescale and clip the registered product.
    always_comb begin
        r    = RW'(prod_q) + (rm2_q ? HALF : '0);
        s    = r >>> SHIFT;
        s_ov = s > MAX_R;
        s_un = s < MIN_R;
    end

    // Next state of all pipeline stages; hold everything while stalled.
    always_comb begin
        v1_d   = v1_q;
        a1_d   = a1_q;
        b1_d   = b1_q;
        rm1_d  = rm1_q;
        v2_d   = v2_q;
        prod_d = prod_q;
        rm2_d  = rm2_q;
        v3_d   = v3_q;
        p_d    = p_q;
        ov_d   = ov_q;
        un_d   = un_q;
        if (en) begin
            v1_d   = bus.in_valid;
            a1_d   = bus.a_in;
            b1_d   = bus.b_in;
            rm1_d  = bus.round_mode;
            v2_d   = v1_q;
            prod_d = PW'(a1_q) * PW'(b1_q);
            rm2_d  = rm1_q;
            v3_d   = v2_q;
            ov_d   = s_ov;
            un_d   = s_un;
            if (s_ov) begin
                p_d = MAX_U[OUT_W-1:0];
            end else if (s_un) begin
                p_d = MIN_U[OUT_W-1:0];
            end else begin
                p_d = s[OUT_W-1:0];
            end
        end
    end

    // Clip counters count accepted results only; clear beats increment.
    always_comb begin
        pos_d = pos_q;
        neg_d = neg_q;
        if (clr_cnt) begin
            pos_d = '0;
            neg_d = '0;
        end else begin
            if (acc && ov_q && (pos_q != '1)) begin
                pos_d = pos_q + 1'b1;
            end
            if (acc && un_q && (neg_q != '1)) begin
                neg_d = neg_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset that drops all in-flight data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            a1_q   <= '0;
            b1_q   <= '0;
            rm1_q  <= 1'b0;
            v2_q   <= 1'b0;
            prod_q <= '0;
            rm2_q  <= 1'b0;
            v3_q   <= 1'b0;
            p_q    <= '0;
            ov_q   <= 1'b0;
            un_q   <= 1'b0;
            pos_q  <= '0;
            neg_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            a1_q   <= a1_d;
            b1_q   <= b1_d;
            rm1_q  <= rm1_d;
            v2_q   <= v2_d;
            prod_q <= prod_d;
            rm2_q  <= rm2_d;
            v3_q   <= v3_d;
            p_q    <= p_d;
            ov_q   <= ov_d;
            un_q   <= un_d;
            pos_q  <= pos_d;
            neg_q  <= neg_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = v3_q;
    assign bus.p_out     = p_q;
    assign bus.overflow  = ov_q;
    assign bus.underflow = un_q;
    assign sat_pos_cnt   = pos_q;
    assign sat_neg_cnt   = neg_q;
endmodule

// File: tb/tb_fixed_sat_mult_pipe.sv
// Directed bench for fixed_sat_mult_pipe: Q24.8 x Q24.8 -> Q8.8, CNT_W = 2.
// Expected results are hand-computed constants; counters follow a small model.
module tb_fixed_sat_mult_pipe;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [15:0] BP_PAT = 16'b1011_0010_0110_1001;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        rm;
        logic [15:0] p;
        logic        ov;
        logic        un;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_cnt;
    logic [CNT_W-1:0] sat_pos_cnt;
    logic [CNT_W-1:0] sat_neg_cnt;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   pos_m    = 0;
    int   neg_m    = 0;
    vec_t stim[$];

    always #5 clk = ~clk;

    fixed_sat_mult_pipe_if #(.IN_W(32), .OUT_W(16)) bus ();

    fixed_sat_mult_pipe #(
        .IN_W(32), .IN_FRAC(8), .OUT_W(16), .OUT_FRAC(8), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .clr_cnt(clr_cnt),
        .sat_pos_cnt(sat_pos_cnt),
        .sat_neg_cnt(sat_neg_cnt)
    );

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic rm,
                                logic [15:0] p, logic ov, logic un);
        vec_t v;
        v.a = a; v.b = b; v.rm = rm; v.p = p; v.ov = ov; v.un = un;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic ov, input logic un, input bit clr);
        if (clr) begin
            pos_m = 0;
            neg_m = 0;
        end else begin
            if (ov && pos_m < CNT_MAX) pos_m++;
            if (un && neg_m < CNT_MAX) neg_m++;
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_pos_cnt"}, 64'(sat_pos_cnt), 64'(pos_m));
        chk({tag, "_neg_cnt"}, 64'(sat_neg_cnt), 64'(neg_m));
    endtask

    task automatic chk_res(input string tag, input vec_t v);
        chk({tag, "_p"}, 64'(bus.p_out), 64'(v.p));
        chk({tag, "_ov"}, 64'(bus.overflow), 64'(v.ov));
        chk({tag, "_un"}, 64'(bus.underflow), 64'(v.un));
    endtask

    // One isolated transfer with out_ready high: checks 3-cycle latency.
    task automatic run_one(input string tag, input vec_t v, input bit clr);
        @(negedge clk);
        chk_cnt({tag, "_pre"});
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.a_in       = v.a;
        bus.b_in       = v.b;
        bus.round_mode = v.rm;
        #1;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_lat2"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_lat3"}, 64'(bus.out_valid), 64'd1);
        chk_res(tag, v);
        clr_cnt = clr;
        model_accept(v.ov, v.un, clr);
        @(negedge clk);
        clr_cnt = 1'b0;
        chk({tag, "_drain"}, 64'(bus.out_valid), 64'd0);
        chk_cnt({tag, "_post"});
    endtask

    // Streams stim[] back-to-back, optionally with patterned out_ready.
    task automatic stream(input string tag, input bit bp);
        vec_t        exp_q[$];
        int          idx  = 0;
        int          cyc  = 0;
        bit          hold = 1'b0;
        logic [15:0] hp   = '0;
        logic        hov  = 1'b0;
        logic        hun  = 1'b0;
        while ((idx < stim.size() || exp_q.size() != 0) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            chk_cnt(tag);
            if (hold) begin
                chk({tag, "_hold_v"}, 64'(bus.out_valid), 64'd1);
                chk({tag, "_hold_p"}, 64'(bus.p_out), 64'(hp));
                chk({tag, "_hold_ov"}, 64'(bus.overflow), 64'(hov));
                chk({tag, "_hold_un"}, 64'(bus.underflow), 64'(hun));
            end
            bus.out_ready = bp ? BP_PAT[cyc % 16] : 1'b1;
            clr_cnt = 1'b0;
            if (idx < stim.size()) begin
                bus.in_valid   = 1'b1;
                bus.a_in       = stim[idx].a;
                bus.b_in       = stim[idx].b;
                bus.round_mode = stim[idx].rm;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            chk({tag, "_in_ready"}, 64'(bus.in_ready),
                64'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid && bus.out_ready) begin
                chk({tag, "_spurious"}, 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk_res(tag, exp_q[0]);
                    model_accept(exp_q[0].ov, exp_q[0].un, 1'b0);
                    void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(stim[idx]);
                idx++;
            end
            hold = bus.out_valid && !bus.out_ready;
            hp   = bus.p_out;
            hov  = bus.overflow;
            hun  = bus.underflow;
        end
        chk({tag, "_left"}, 64'(stim.size() - idx + exp_q.size()), 64'd0);
        stim.delete();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        clr_cnt        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.a_in       = '0;
        bus.b_in       = '0;
        bus.round_mode = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_p", 64'(bus.p_out), 64'd0);
        chk("rst_ov", 64'(bus.overflow), 64'd0);
        chk("rst_un", 64'(bus.underflow), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk_cnt("rst");

        run_one("mul_2x3", mk(32'h200, 32'h300, 0, 16'h0600, 0, 0), 0);
        run_one("mul_m2x3", mk(32'hFFFFFE00, 32'h300, 0, 16'hFA00, 0, 0), 0);

        run_one("sat_pos", mk(32'h6400, 32'h200, 0, 16'h7FFF, 1, 0), 0);
        run_one("sat_neg", mk(32'hFFFF9C00, 32'h200, 0, 16'h8000, 0, 1), 0);
        run_one("exact_max", mk(32'h7FFF, 32'h100, 0, 16'h7FFF, 0, 0), 0);
        run_one("exact_min", mk(32'hFFFF8000, 32'h100, 0, 16'h8000, 0, 0), 0);
        run_one("minxmin", mk(32'h80000000, 32'h80000000, 0, 16'h7FFF, 1, 0), 0);

        run_one("rnd_p_t", mk(32'h1, 32'h80, 0, 16'h0000, 0, 0), 0);
        run_one("rnd_p_r", mk(32'h1, 32'h80, 1, 16'h0001, 0, 0), 0);
        run_one("rnd_n_t", mk(32'hFFFFFFFF, 32'h80, 0, 16'hFFFF, 0, 0), 0);
        run_one("rnd_n_r", mk(32'hFFFFFFFF, 32'h80, 1, 16'h0000, 0, 0), 0);

        stim.push_back(mk(32'h1, 32'h80, 0, 16'h0000, 0, 0));
        stim.push_back(mk(32'h1, 32'h80, 1, 16'h0001, 0, 0));
        stim.push_back(mk(32'hFFFFFFFF, 32'h80, 0, 16'hFFFF, 0, 0));
        stim.push_back(mk(32'hFFFFFFFF, 32'h80, 1, 16'h0000, 0, 0));
        stim.push_back(mk(32'h3, 32'h55, 0, 16'h0000, 0, 0));
        stim.push_back(mk(32'h3, 32'h55, 1, 16'h0001, 0, 0));
        stream("alt_rm", 1'b0);

        stim.push_back(mk(32'h100, 32'h100, 0, 16'h0100, 0, 0));
        stim.push_back(mk(32'h180, 32'h200, 0, 16'h0300, 0, 0));
        stim.push_back(mk(32'hFFFFFF00, 32'h500, 0, 16'hFB00, 0, 0));
        stim.push_back(mk(32'h6400, 32'h200, 0, 16'h7FFF, 1, 0));
        stim.push_back(mk(32'h40, 32'h40, 0, 16'h0010, 0, 0));
        stim.push_back(mk(32'hFFFF9C00, 32'h200, 0, 16'h8000, 0, 1));
        stim.push_back(mk(32'hA00, 32'hC00, 0, 16'h7800, 0, 0));
        stim.push_back(mk(32'h3, 32'h55, 1, 16'h0001, 0, 0));
        stream("bp", 1'b1);

        @(negedge clk);
        clr_cnt = 1'b1;
        model_accept(0, 0, 1);
        @(negedge clk);
        clr_cnt = 1'b0;
        chk_cnt("clr");
        repeat (5) stim.push_back(mk(32'h6400, 32'h200, 0, 16'h7FFF, 1, 0));
        stream("cnt_sat", 1'b0);
        chk("cnt_sat_final", 64'(sat_pos_cnt), 64'd3);

        run_one("clr_win", mk(32'h6400, 32'h200, 0, 16'h7FFF, 1, 0), 1);

        repeat (4) stim.push_back(mk(32'h6400, 32'h200, 0, 16'h7FFF, 1, 0));
        stim.push_back(mk(32'hFFFF9C00, 32'h200, 0, 16'h8000, 0, 1));
        stream("cnt_hold", 1'b1);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid   = 1'b1;
            bus.a_in       = 32'h6400;
            bus.b_in       = 32'h200;
            bus.round_mode = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_accept(0, 0, 1);
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_p", 64'(bus.p_out), 64'd0);
        chk("midrst_ov", 64'(bus.overflow), 64'd0);
        chk_cnt("midrst");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_stale", 64'(bus.out_valid), 64'd0);
        end
        run_one("after_rst", mk(32'h200, 32'h300, 0, 16'h0600, 0, 0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fixed_sat_mult_pipe.md
Name: fixed_sat_mult_pipe

Overview:
- Parametrised, pipelined, saturating signed fixed-point multiplier for the gradient-descent datapath.
- Takes two Qm.n operands of width IN_W and produces a capped result of width OUT_W, with selectable truncate or round-half-up.
- Uses a valid/ready handshake with backpressure.
- Keeps saturating counters of positive and negative clip events so software can monitor step-size overflow.

Parameters:
- IN_W, 32: operand width (signed two's complement).
- IN_FRAC, 8: fractional bits of each operand.
- OUT_W, 16: result width.
- OUT_FRAC, 8: fractional bits of the result. Constraint: 2*IN_FRAC >= OUT_FRAC.
- CNT_W, 16: width of each saturation event counter.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: operand pair valid.
- in_ready, out, 1: block can accept an operand pair this cycle.
- a_in, in, IN_W: signed operand A.
- b_in, in, IN_W: signed operand B.
- round_mode, in, 1: 0 = truncate (floor); 1 = round half up. Sampled with the operands.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts the result.
- p_out, out, OUT_W: signed capped result.
- overflow, out, 1: p_out was clipped to MAX. Qualified by out_valid.
- underflow, out, 1: p_out was clipped to MIN. Qualified by out_valid.
- clr_cnt, in, 1: synchronous clear of both counters.
- sat_pos_cnt, out, CNT_W: count of accepted results with overflow = 1.
- sat_neg_cnt, out, CNT_W: count of accepted results with underflow = 1.

Behaviour:
- Derived constants:
  - SHIFT = 2*IN_FRAC - OUT_FRAC.
  - MAX = 2^(OUT_W-1) - 1.
  - MIN = -2^(OUT_W-1).
- Three register stages, each with its own valid bit:
  - S1 registers a_in, b_in and round_mode.
  - S2 registers the full signed product, 2*IN_W bits.
  - S3 registers p_out, overflow and underflow.
- Global advance enable: en = out_ready | ~out_valid. in_ready = en.
  - A transfer in occurs when in_valid & in_ready; S1 valid then loads in_valid.
  - When en = 0, all stages hold, including internal valid bits.
  - Internal bubbles are not collapsed.
- Latency: 3 cycles from input transfer to out_valid with out_ready held high. Throughput is 1 per cycle.
- Stage 3 arithmetic, using (2*IN_W + 1)-bit signed intermediates:
  - r = product + (round_mode && SHIFT > 0 ? 2^(SHIFT-1) : 0).
  - s = r >>> SHIFT (arithmetic shift).
  - overflow = s > MAX; underflow = s < MIN.
  - p_out = MAX if overflow, MIN if underflow, otherwise s[OUT_W-1:0].
  - overflow and underflow are never both 1.
- Rounding is half toward +infinity: -0.5 LSB rounds to 0, +0.5 LSB rounds to +1.
- Outputs hold stable while out_valid & ~out_ready. This is the AXI-style rule: no change until accepted.
- Counters:
  - Increment by 1 on an output transfer (out_valid & out_ready) whose flag is set.
  - Saturate at all-ones; they never wrap.
- Simultaneous clr_cnt and increment: clear wins, counter becomes 0.
- Reset:
  - All valid bits 0, so out_valid = 0.
  - p_out = 0, overflow = 0, underflow = 0.
  - Both counters = 0.
  - in_ready = 1 in the first cycle after reset.
  - Reset mid-operation discards all in-flight data, and nothing is emitted for it.
- Combinational paths: in_ready depends combinationally on out_ready. No other input-to-output combinational paths.
- The SHIFT = 0 configuration is legal; round_mode has no effect in that case.

Test Plan (defaults, Q24.8 in, Q8.8 out):
1. Basic products, round_mode = 0, out_ready = 1.
   - a = 0x00000200 (2.0), b = 0x00000300 (3.0) -> p_out = 0x0600, flags 0, out_valid exactly 3 cycles after the transfer.
   - a = 0xFFFFFE00 (-2.0), b = 0x00000300 -> p_out = 0xFA00.
2. Saturation.
   - a = 0x00006400 (100.0), b = 0x00000200 -> p_out = 0x7FFF, overflow = 1, sat_pos_cnt = 1.
   - a = 0xFFFF9C00 (-100.0), b = 0x00000200 -> p_out = 0x8000, underflow = 1, sat_neg_cnt = 1.
   - a = 0x00007FFF, b = 0x00000100 -> 0x7FFF with flags 0 (exact max, not clipped).
3. Rounding.
   - a = 0x00000001, b = 0x00000080: round_mode 0 -> 0x0000; round_mode 1 -> 0x0001.
   - a = 0xFFFFFFFF, b = 0x00000080: round_mode 0 -> 0xFFFF; round_mode 1 -> 0x0000.
   - Alternate round_mode every cycle in a back-to-back stream -> each result uses its own sampled mode.
4. Backpressure.
   - Stream 8 operand pairs with out_ready toggling pseudo-randomly -> all 8 results in order, none lost or duplicated.
   - p_out and flags remain stable while out_valid & ~out_ready.
   - in_ready = 0 exactly when out_valid & ~out_ready.
5. Counters, with CNT_W = 2.
   - 5 overflowing transfers -> sat_pos_cnt goes 1, 2, 3, 3, 3.
   - Assert clr_cnt in the same cycle as an overflow transfer -> 0.
   - Overflow results held under ~out_ready are not counted until accepted.
6. Reset mid-stream.
   - Assert rst with 3 results in flight -> out_valid = 0, p_out = 0, counters = 0 next cycle.
   - No stale results appear after rst deasserts.
   - A new input yields its result 3 cycles later.
